// File: rtl/apb2ahb_bridge.sv
// ============================================================================
// apb2ahb_bridge : APB3 completer to single-master AHB-Lite initiator bridge.
// Optional APB4_EN adds PSTRB/PPROT mapping to HSIZE/HADDR offset/HPROT.
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb2ahb_bridge #(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
`ifdef APB4_EN
  input  logic [3:0]           PSTRB,
  input  logic [2:0]           PPROT,
`endif
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic [ADDRWIDTH-1:0] HADDR,
  output logic [1:0]           HTRANS,
  output logic                 HWRITE,
  output logic [2:0]           HSIZE,
  output logic [3:0]           HPROT,
  output logic [DATAWIDTH-1:0] HWDATA,
  input  logic [DATAWIDTH-1:0] HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [2:0] SIZE_WORD    = 3'b010;
  localparam logic [3:0] PROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state;

  logic [ADDRWIDTH-1:0] setup_addr;
  logic [2:0]           setup_size;
  logic [3:0]           setup_prot;
  logic                 setup_bad;

`ifdef APB4_EN
  logic       strb_ok;
  logic [2:0] strb_size;
  logic [1:0] strb_off;
  logic       unused_apb4;

  // Only naturally aligned byte/half/word strobe patterns map onto one AHB beat.
  always_comb begin
    strb_ok   = 1'b1;
    strb_size = SIZE_WORD;
    strb_off  = 2'd0;
    case (PSTRB)
      4'b1111: begin strb_size = 3'b010; strb_off = 2'd0; end
      4'b0011: begin strb_size = 3'b001; strb_off = 2'd0; end
      4'b1100: begin strb_size = 3'b001; strb_off = 2'd2; end
      4'b0001: begin strb_size = 3'b000; strb_off = 2'd0; end
      4'b0010: begin strb_size = 3'b000; strb_off = 2'd1; end
      4'b0100: begin strb_size = 3'b000; strb_off = 2'd2; end
      4'b1000: begin strb_size = 3'b000; strb_off = 2'd3; end
      default: strb_ok = 1'b0;
    endcase
  end

  always_comb begin
    setup_addr = {PADDR[ADDRWIDTH-1:2], 2'b00};
    setup_size = SIZE_WORD;
    setup_bad  = 1'b0;
    if (PWRITE) begin
      setup_addr = {PADDR[ADDRWIDTH-1:2], strb_off};
      setup_size = strb_size;
      setup_bad  = ~strb_ok;
    end
  end

  assign setup_prot  = {2'b00, PPROT[0], ~PPROT[2]};
  assign unused_apb4 = ^{PPROT[1], PADDR[1:0]};
`else
  assign setup_addr = PADDR;
  assign setup_size = SIZE_WORD;
  assign setup_prot = PROT_DEFAULT;
  assign setup_bad  = 1'b0;
`endif

  // Once the setup phase is accepted the AHB transfer always runs to completion,
  // even if the APB side drops PSEL.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      HTRANS  <= TRANS_IDLE;
      HADDR   <= '0;
      HWRITE  <= 1'b0;
      HWDATA  <= '0;
      HSIZE   <= SIZE_WORD;
      HPROT   <= PROT_DEFAULT;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          PREADY <= 1'b0;
          HTRANS <= TRANS_IDLE;
          if (PSEL && !PENABLE) begin
            HADDR  <= setup_addr;
            HWRITE <= PWRITE;
            HWDATA <= PWDATA;
            HSIZE  <= setup_size;
            HPROT  <= setup_prot;
            if (setup_bad) begin
              state   <= ST_DONE;
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
            end else begin
              state  <= ST_ADDR;
              HTRANS <= TRANS_NONSEQ;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            HTRANS <= TRANS_IDLE;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (HREADY) begin
            if (!HWRITE) begin
              PRDATA <= HRDATA;
            end
            PSLVERR <= HRESP;
            PREADY  <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          HTRANS <= TRANS_IDLE;
          PREADY <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_apb2ahb_bridge.sv
// ============================================================================
// tb_apb2ahb_bridge : directed self-checking bench for apb2ahb_bridge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb2ahb_bridge;

  logic        HCLK;
  logic        HRESET;
  logic        PSEL;
  logic        PENABLE;
  logic [15:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
`ifdef APB4_EN
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
`endif
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [15:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  apb2ahb_bridge #(.ADDRWIDTH(16), .DATAWIDTH(32)) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
`ifdef APB4_EN
    .PSTRB   (PSTRB),
    .PPROT   (PPROT),
`endif
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .HADDR   (HADDR),
    .HTRANS  (HTRANS),
    .HWRITE  (HWRITE),
    .HSIZE   (HSIZE),
    .HPROT   (HPROT),
    .HWDATA  (HWDATA),
    .HRDATA  (HRDATA),
    .HREADY  (HREADY),
    .HRESP   (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_prdata;
  int          compared;
  int          mismatched;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("prdata", PRDATA, e.rdata);
      chk("pslverr", 32'(PSLVERR), 32'(e.err));
    end
  endtask

  // One APB transfer; the AHB completer response is scripted per cycle from
  // aw address-phase waits and dw data-phase waits.
  task automatic xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                      input int aw, input int dw, input logic err, input logic [31:0] rdata);
    exp_t e;
    int   nonseq;
    bit   done;
    int   last_a;
    int   last_d;
    if (!wr) model_prdata = rdata;
    e.rdata = model_prdata;
    e.err   = err;
    sb.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = JUNK;
    last_a = aw + 1;
    last_d = aw + 2 + dw;
    nonseq = 0;
    done   = 1'b0;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      step();
      PENABLE = 1'b1;
      if (cyc <= last_a) begin
        chk("htrans_addr", 32'(HTRANS), 32'h2);
        chk("haddr", 32'(HADDR), 32'(addr));
        chk("hwrite", 32'(HWRITE), 32'(wr));
        HREADY = (cyc == last_a);
        HRESP  = 1'b0;
      end else if (cyc <= last_d) begin
        chk("htrans_data", 32'(HTRANS), 32'h0);
        if (wr) chk("hwdata", HWDATA, wdata);
        HREADY = (cyc == last_d);
        HRESP  = err && (cyc >= last_d - 1);
        HRDATA = (cyc == last_d) ? rdata : JUNK;
      end else begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = JUNK;
      end
      if (HTRANS == 2'b10 && HREADY) nonseq++;
      if (PREADY) begin
        done = 1'b1;
        chk("pready_cycle", 32'(cyc), 32'(last_d + 1));
        sb_check();
      end
    end
    chk("pready_seen", 32'(done), 32'd1);
    chk("nonseq_count", 32'(nonseq), 32'd1);
    PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = JUNK;
    step();
    chk("pready_after", 32'(PREADY), 32'd0);
    chk("pslverr_after", 32'(PSLVERR), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    compared = 0; mismatched = 0; model_prdata = 32'h0;
    HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PADDR = 16'h0; PWRITE = 1'b0;
    PWDATA = 32'h0; HRDATA = JUNK; HREADY = 1'b1; HRESP = 1'b0;
`ifdef APB4_EN
    PSTRB = 4'hF; PPROT = 3'b000;
`endif
    step();
    step();
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr", 32'(HADDR), 32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_hsize", 32'(HSIZE), 32'h2);
    chk("rst_hprot", 32'(HPROT), 32'h3);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pready", 32'(PREADY), 32'h0);
    chk("rst_pslverr", 32'(PSLVERR), 32'h0);
    HRESET = 1'b0;
    step();

    // Zero-wait write, read with data waits, error response, back-to-back.
    xfer(16'h0040, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0, JUNK);
    xfer(16'h0044, 1'b0, 32'h0,         0, 2, 1'b0, 32'h1234_5678);
    xfer(16'h0048, 1'b0, 32'h0,         0, 1, 1'b1, 32'hCAFE_0001);
    xfer(16'h004C, 1'b1, 32'h0BAD_F00D, 0, 0, 1'b0, JUNK);
    xfer(16'h0050, 1'b0, 32'h0,         2, 0, 1'b0, 32'hA5A5_5A5A);
    xfer(16'h0054, 1'b1, 32'h1111_2222, 1, 3, 1'b1, JUNK);

    // Reset while in DATA abandons the transfer.
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h0060; PWRITE = 1'b0; HREADY = 1'b1;
    step();
    PENABLE = 1'b1;
    step();
    chk("rstmid_in_data", 32'(HTRANS), 32'h0);
    HREADY = 1'b0;
    HRESET = 1'b1;
    step();
    HRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
    chk("rstmid_htrans", 32'(HTRANS), 32'h0);
    chk("rstmid_pready", 32'(PREADY), 32'h0);
    chk("rstmid_prdata", PRDATA, 32'h0);
    model_prdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rstmid_no_pready", 32'(PREADY), 32'h0);
    end
    xfer(16'h0080, 1'b0, 32'h0, 0, 0, 1'b0, 32'h8080_0808);

`ifdef APB4_EN
    // Byte write at lane 2 with PPROT mapping.
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h0010; PWRITE = 1'b1; PWDATA = 32'h00AB_0000;
    PSTRB = 4'b0100; PPROT = 3'b101;
    step();
    PENABLE = 1'b1;
    chk("apb4_haddr", 32'(HADDR), 32'h0012);
    chk("apb4_hsize", 32'(HSIZE), 32'h0);
    chk("apb4_hprot", 32'(HPROT), 32'h2);
    chk("apb4_htrans", 32'(HTRANS), 32'h2);
    step();
    step();
    chk("apb4_pready", 32'(PREADY), 32'h1);
    chk("apb4_pslverr", 32'(PSLVERR), 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    step();
    // Illegal strobe: immediate error, no AHB transfer.
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h0020; PWRITE = 1'b1; PSTRB = 4'b0101;
    step();
    PENABLE = 1'b1;
    chk("apb4_bad_pready", 32'(PREADY), 32'h1);
    chk("apb4_bad_pslverr", 32'(PSLVERR), 32'h1);
    chk("apb4_bad_htrans", 32'(HTRANS), 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0; PSTRB = 4'hF; PPROT = 3'b000;
    step();
    chk("apb4_bad_after", 32'(PREADY), 32'h0);
    chk("apb4_bad_htrans_after", 32'(HTRANS), 32'h0);
`endif

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb2ahb_bridge.md
Name: apb2ahb_bridge

Overview:
- Bridges in the opposite direction to our AHB-to-APB bridge: an APB3 completer on the upstream side and a single-master AHB-Lite initiator on the downstream side.
- Each APB transfer becomes exactly one single (NONSEQ) AHB transfer.
- APB wait states (PREADY low) are inserted until the AHB data phase completes.
- Used where an APB-only agent (debug port, slow CPU) must reach AHB memory.

Parameters:
- ADDRWIDTH, 16, width of PADDR and HADDR.
- DATAWIDTH, 32, width of all data buses. Fixed word size; HSIZE word equals 3'b010.

Ports:
- HCLK  input  1  single clock for both the APB and AHB sides.
- HRESET  input  1  synchronous, active-high reset.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB access phase.
- PADDR  input  ADDRWIDTH  APB address.
- PWRITE  input  1  APB direction; 1 = write.
- PWDATA  input  DATAWIDTH  APB write data.
- PRDATA  output  DATAWIDTH  APB read data (registered).
- PREADY  output  1  APB transfer complete.
- PSLVERR  output  1  APB error; valid only when PREADY = 1.
- HADDR  output  ADDRWIDTH  AHB address.
- HTRANS  output  2  AHB transfer type: IDLE = 2'b00 or NONSEQ = 2'b10 only.
- HWRITE  output  1  AHB direction.
- HSIZE  output  3  AHB transfer size.
- HPROT  output  4  AHB protection.
- HWDATA  output  DATAWIDTH  AHB write data.
- HRDATA  input  DATAWIDTH  AHB read data.
- HREADY  input  1  AHB ready.
- HRESP  input  1  AHB error response.

Behaviour:
- Reset, synchronous on HCLK edge with HRESET = 1:
  - State = IDLE.
  - HTRANS = 0, HADDR = 0, HWRITE = 0, HWDATA = 0.
  - HSIZE = 3'b010, HPROT = 4'b0011.
  - PRDATA = 0, PREADY = 0, PSLVERR = 0.
  - Reset mid-transfer abandons the transfer; no PREADY is issued for it. HTRANS = IDLE from the next cycle.
- State machine (registered outputs):
  - IDLE:
    - PREADY = 0, HTRANS = IDLE.
    - On PSEL = 1 and PENABLE = 0 (APB setup phase): latch PADDR, PWRITE and PWDATA into HADDR, HWRITE and HWDATA; go to ADDR.
  - ADDR:
    - HTRANS = NONSEQ; HADDR and HWRITE held.
    - HREADY = 1: go to DATA.
    - HREADY = 0: stay, holding all control signals stable (address-phase extension).
  - DATA:
    - HTRANS = IDLE; HWDATA held stable.
    - HREADY = 1: capture HRDATA into PRDATA (reads only; PRDATA is unchanged on writes) and HRESP into PSLVERR; go to DONE.
    - HREADY = 0 with HRESP = 1 (first cycle of the 2-cycle error response): stay, no retry or cancel needed.
  - DONE:
    - PREADY = 1 for exactly one cycle; PRDATA and PSLVERR are valid.
    - Go to IDLE.
    - PSLVERR clears to 0 when DONE is exited.
- Latency with zero AHB wait states:
  - Setup at cycle 0, ADDR at cycle 1, DATA at cycle 2, PREADY = 1 at cycle 3.
  - Each AHB wait state adds one cycle.
- Back-to-back APB transfers: the next setup phase occurs the cycle after DONE and is accepted from IDLE. There are no pipelined AHB transfers.
- PSEL dropped mid-transfer (protocol violation): the AHB transfer still completes; the result is discarded and DONE returns to IDLE.
- PREADY is never high outside DONE.

Optional Feature:
- Macro: APB4_EN.
- Defined: adds inputs PSTRB (4 bits) and PPROT (3 bits).
  - HPROT = {2'b00, PPROT[0], ~PPROT[2]}.
  - Writes map PSTRB to size and offset; HADDR = {PADDR[ADDRWIDTH-1:2], offset}:
    - 4'b1111: word, offset 0.
    - 4'b0011: half, offset 0.
    - 4'b1100: half, offset 2.
    - One-hot strobe: byte, offset = bit index.
  - Any other write strobe pattern, including 0: no AHB transfer; go directly to DONE with PSLVERR = 1.
  - Reads ignore PSTRB and use word size.
- Undefined: ports absent; HSIZE = 3'b010, HPROT = 4'b0011, HADDR = PADDR.

Test Plan:
- Write with zero waits: PADDR = 0x0040, PWDATA = 0xDEADBEEF, PWRITE = 1.
  - Required: cycle 1 HTRANS = 2'b10, HADDR = 0x0040, HWRITE = 1.
  - Required: cycle 2 HWDATA = 0xDEADBEEF, HTRANS = 0.
  - Required: cycle 3 PREADY = 1, PSLVERR = 0.
- Read with 2 AHB data-phase waits, HRDATA = 0x12345678:
  - Required: PREADY = 1 only at cycle 5, PRDATA = 0x12345678.
  - Required: exactly one NONSEQ observed.
- Error response: HREADY/HRESP = 0/1 then 1/1 in DATA.
  - Required: PSLVERR = 1 with PREADY = 1; no second NONSEQ.
  - Required: next transfer returns PSLVERR = 0.
- Address-phase wait: HREADY = 0 for 2 cycles during ADDR.
  - Required: HTRANS = NONSEQ and HADDR stable for 3 cycles; PREADY at cycle 5.
- Reset mid-op: HRESET = 1 for one cycle while in DATA.
  - Required: next cycle HTRANS = 0, PREADY = 0, PRDATA = 0.
  - Required: a subsequent read of 0x0080 completes normally.
- APB4_EN:
  - PSTRB = 4'b0100, PADDR = 0x0010: required HADDR = 0x0012, HSIZE = 3'b000.
  - PSTRB = 4'b0101: required PSLVERR = 1 at cycle 1, no NONSEQ issued.
